// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: request-side controller for a 512x32 single-port RAM.
// Sequences RAM strobes, covers read latency, does RMW for byte stores.
module ram_port_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                ram_read,
  output logic                ram_write,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_FULL = '1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_RMW_RD   = 3'd3;
  localparam logic [2:0] S_RMW_WAIT = 3'd4;
  localparam logic [2:0] S_WR       = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              accept;
  logic              addr_err;
  logic [DATA_W-1:0] merged;

  assign accept   = req_valid && (state_q == S_IDLE);
  assign addr_err = (req_addr[1:0] != 2'b00) ||
                    (req_addr[31:ADDR_W+2] != '0);

  always_comb begin
    merged = ram_rdata;
    for (int i = 0; i < BE_W; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr[ADDR_W+1:2];
          be_d    = req_be;
          wdata_d = req_wdata;
          if (addr_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (!req_we) begin
            state_d = S_RD;
          end else if (req_be == BE_FULL) begin
            state_d = S_WR;
          end else if (req_be != '0) begin
            state_d = S_RMW_RD;
          end else begin
            rsp_valid_d = 1'b1;
          end
        end
      end
      S_RD:       state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ram_rdata;
      end
      S_RMW_RD:   state_d = S_RMW_WAIT;
      S_RMW_WAIT: begin
        state_d = S_WR;
        wdata_d = merged;
      end
      S_WR: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // strobes gated by rst_n so a reset edge never touches the RAM
  assign ram_read  = rst_n &&
                     ((state_q == S_RD) || (state_q == S_RMW_RD));
  assign ram_write = rst_n && (state_q == S_WR);
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: random + directed bench with a latency-table model
// of the controller and a behavioural RAM behind it.
module tb_ram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_read;
  logic        ram_write;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  ram_port_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_read(ram_read), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  function automatic logic [31:0] seed_word(input int i);
    return (32'h9E3779B9 * i) + 32'h12345678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // behavioural RAM: registered read, one write port
  logic [31:0] ram [512];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= seed_word(i);
      ram_init <= 1'b1;
    end else begin
      if (ram_write === 1'b1) ram[ram_addr] <= ram_wdata;
      if (ram_read === 1'b1) ram_rdata <= ram[ram_addr];
    end
  end

  int rd_cnt = 0;
  int wr_cnt = 0;
  int rsp_cnt = 0;
  logic [31:0] last_wdata = 32'h0;
  logic [8:0]  last_waddr = 9'h0;
  always @(posedge clk) begin
    if (ram_read === 1'b1) rd_cnt <= rd_cnt + 1;
    if (ram_write === 1'b1) begin
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= ram_wdata;
      last_waddr <= ram_addr;
    end
    if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
  end

  // reference model: one request in flight, latency by request kind
  localparam int K_ERR = 0, K_NOP = 1, K_FULL = 2, K_LOAD = 3, K_PART = 4;
  logic [31:0] mmem [512];
  bit          started = 1'b0;
  bit          busy = 1'b0;
  int          m_t = 0;
  int          m_lat = 0;
  int          kind = K_NOP;
  logic [8:0]  m_word = 9'h0;
  logic [3:0]  m_be = 4'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [8:0]  last_addr = 9'h0;

  always @(negedge clk) begin : model
    logic erv, erdy, erd, ewr;
    if (started) begin
      erv  = busy && (m_t == m_lat);
      erdy = !busy || erv;
      erd  = rst_n && busy && (m_t == 1) &&
             (kind == K_LOAD || kind == K_PART);
      ewr  = rst_n && busy &&
             ((kind == K_FULL && m_t == 1) ||
              (kind == K_PART && m_t == 3));
      chk("req_ready", {31'b0, req_ready}, {31'b0, erdy});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, erv});
      chk("ram_read", {31'b0, ram_read}, {31'b0, erd});
      chk("ram_write", {31'b0, ram_write}, {31'b0, ewr});
      chk("ram_addr", {23'b0, ram_addr}, {23'b0, last_addr});
      if (ewr)
        chk("ram_wdata", ram_wdata, merge(mmem[m_word], m_wdata, m_be));
      if (erv) begin
        chk("rsp_err", {31'b0, rsp_err}, (kind == K_ERR) ? 32'd1 : 32'd0);
        chk("rsp_rdata", rsp_rdata,
            (kind == K_LOAD) ? mmem[m_word] : 32'h0);
        if (kind == K_FULL || kind == K_PART)
          mmem[m_word] = merge(mmem[m_word], m_wdata, m_be);
      end
    end
    if (!rst_n) begin
      if (!started)
        for (int i = 0; i < 512; i++) mmem[i] = seed_word(i);
      started   = 1'b1;
      busy      = 1'b0;
      last_addr = 9'h0;
    end else if (started) begin
      if (busy && m_t == m_lat) busy = 1'b0;
      else if (busy) m_t++;
      if (!busy && req_valid) begin
        busy      = 1'b1;
        m_t       = 1;
        m_word    = req_addr[10:2];
        m_be      = req_be;
        m_wdata   = req_wdata;
        last_addr = req_addr[10:2];
        if (req_addr[1:0] != 2'b00 || req_addr >= 32'h800) begin
          kind = K_ERR;  m_lat = 1;
        end else if (!req_we) begin
          kind = K_LOAD; m_lat = 3;
        end else if (req_be == 4'h0) begin
          kind = K_NOP;  m_lat = 1;
        end else if (req_be == 4'hF) begin
          kind = K_FULL; m_lat = 2;
        end else begin
          kind = K_PART; m_lat = 4;
        end
      end
    end
  end

  task automatic txn(input logic we, input logic [3:0] be,
                     input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd,
                     output logic er, output int nrd, output int nwr);
    int rd0, wr0, w;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_be = be;
    req_addr = a; req_wdata = wd;
    rd0 = rd_cnt; wr0 = wr_cnt;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    if (!req_ready) fail("accept_wait");
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; rd = 32'h0; er = 1'b0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        lat = i; rd = rsp_rdata; er = rsp_err;
      end
    end
    if (lat == 0) fail("rsp_wait");
    nrd = rd_cnt - rd0;
    nwr = wr_cnt - wr0;
  endtask

  function automatic logic [31:0] rand_addr();
    int s;
    logic [31:0] w;
    s = $urandom_range(0, 9);
    w = $urandom_range(0, 1) ? 32'($urandom_range(0, 15))
                             : 32'($urandom_range(496, 511));
    if (s == 0) return 32'h7FC;
    if (s == 1) return 32'h800 + (32'($urandom_range(0, 255)) << 2);
    if (s == 2) return $urandom;
    if (s == 3) return (w << 2) | 32'($urandom_range(1, 3));
    return w << 2;
  endfunction

  function automatic logic [3:0] rand_be();
    int s;
    s = $urandom_range(0, 5);
    if (s == 0) return 4'h0;
    if (s <= 2) return 4'hF;
    return 4'($urandom_range(1, 14));
  endfunction

  initial begin : timeout
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, nrd, nwr, acc, r0, w0;
    logic [31:0] rd;
    logic er, nxt_we;
    rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ram_read", {31'b0, ram_read}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_ram_write", {31'b0, ram_write}, 32'd0);
    chk("rst_ram_addr", {23'b0, ram_addr}, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_strobes", rd_cnt + wr_cnt, 32'd0);

    txn(1'b1, 4'hF, 32'h100, 32'hDEADBEEF, lat, rd, er, nrd, nwr);
    chk("full_lat", lat, 2);
    chk("full_nwr", nwr, 1);
    chk("full_nrd", nrd, 0);
    chk("full_waddr", {23'b0, last_waddr}, 32'h040);
    chk("full_wdata", last_wdata, 32'hDEADBEEF);
    txn(1'b0, 4'h0, 32'h100, 32'h0, lat, rd, er, nrd, nwr);
    chk("load_lat", lat, 3);
    chk("load_data", rd, 32'hDEADBEEF);
    chk("load_err", {31'b0, er}, 32'd0);
    chk("load_nrd", nrd, 1);

    txn(1'b1, 4'b0101, 32'h100, 32'h11223344, lat, rd, er, nrd, nwr);
    chk("rmw_lat", lat, 4);
    chk("rmw_nrd", nrd, 1);
    chk("rmw_nwr", nwr, 1);
    chk("rmw_wdata", last_wdata, 32'hDE22BE44);
    txn(1'b0, 4'h0, 32'h100, 32'h0, lat, rd, er, nrd, nwr);
    chk("rmw_load", rd, 32'hDE22BE44);

    txn(1'b0, 4'h0, 32'h102, 32'h0, lat, rd, er, nrd, nwr);
    chk("mis_lat", lat, 1);
    chk("mis_err", {31'b0, er}, 32'd1);
    chk("mis_rdata", rd, 32'h0);
    chk("mis_strobes", nrd + nwr, 0);
    txn(1'b1, 4'hF, 32'h800, 32'h55AA55AA, lat, rd, er, nrd, nwr);
    chk("oor_lat", lat, 1);
    chk("oor_err", {31'b0, er}, 32'd1);
    chk("oor_strobes", nrd + nwr, 0);
    txn(1'b1, 4'h0, 32'h7FC, 32'h12345678, lat, rd, er, nrd, nwr);
    chk("be0_lat", lat, 1);
    chk("be0_err", {31'b0, er}, 32'd0);
    chk("be0_strobes", nrd + nwr, 0);

    txn(1'b1, 4'hF, 32'h7FC, 32'hCAFEF00D, lat, rd, er, nrd, nwr);
    chk("top_st_err", {31'b0, er}, 32'd0);
    txn(1'b0, 4'h0, 32'h7FC, 32'h0, lat, rd, er, nrd, nwr);
    chk("top_load", rd, 32'hCAFEF00D);

    @(posedge clk); #1;
    w0 = wr_cnt; r0 = rsp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'b0011;
    req_addr = 32'h100; req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid_nwr", wr_cnt - w0, 0);
    chk("rstmid_nrsp", rsp_cnt - r0, 0);
    txn(1'b0, 4'h0, 32'h100, 32'h0, lat, rd, er, nrd, nwr);
    chk("rstmid_load", rd, 32'hDE22BE44);

    @(posedge clk); #1;
    acc = 0; r0 = rsp_cnt; nxt_we = 1'b0;
    req_valid = 1'b1; req_we = nxt_we; req_addr = 32'h7FC;
    req_be = 4'hF; req_wdata = $urandom;
    repeat (200) begin
      @(negedge clk);
      er = req_ready;
      @(posedge clk); #1;
      if (er) begin
        acc++;
        nxt_we = !nxt_we;
        req_we = nxt_we;
        req_addr = $urandom_range(0, 1) ? 32'h7FC
                   : (32'($urandom_range(0, 15)) << 2);
        req_be = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(1, 14));
        req_wdata = $urandom;
      end
    end
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("b2b_rsp_per_acc", rsp_cnt - r0, acc);

    repeat (3000) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 399) != 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_we = $urandom_range(0, 1);
      req_be = rand_be();
      req_addr = rand_addr();
      req_wdata = $urandom;
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
